// File: rtl/uart_rx_frame_if.sv
// RX framer output bundle: received byte, frame strobe and status.
// master = framer side, slave = RX FIFO / register stage side.
interface uart_rx_frame_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_parity_err;
  logic              o_frame_err;
  logic              o_busy;

  modport master (
    output o_data,
    output o_valid,
    output o_parity_err,
    output o_frame_err,
    output o_busy
  );

  modport slave (
    input o_data,
    input o_valid,
    input o_parity_err,
    input o_frame_err,
    input o_busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// UART RX framer: syncs i_rx, deframes start/data/parity/stop on i_tick.
// Ports: clk, rst_n, i_tick, i_rx, frame config inputs, rx_out (bundle).
module uart_rx_frame #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       i_rx,
  input  logic       i_parity_en,
  input  logic       i_parity_even,
  input  logic [3:0] i_data_len,
  input  logic [1:0] i_stop_len,
  input  logic [4:0] i_osm,
  input  logic [3:0] i_smp_nth,
  uart_rx_frame_if.master rx_out
);
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic rx_s, rx_d, fall;

  logic       par_en, par_even, stop2;
  logic [3:0] dlen;
  logic [4:0] osm;
  logic [3:0] smp;

  logic [4:0]        tick_cnt;
  logic [BW-1:0]     bit_cnt;
  logic              stop_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_err, frm_err;

  logic [DATA_W-1:0] data_q;
  logic valid_q, pe_q, fe_q;

  logic [3:0] dlen_c;
  logic smp_hit, wrap, last_bit, last_stop, par_exp;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_d & ~rx_s;

  assign dlen_c = (i_data_len < 4'd5) ? 4'd5 :
                  (i_data_len > 4'd8) ? 4'd8 :
                  i_data_len;

  assign smp_hit = i_tick && (tick_cnt == {1'b0, smp});
  assign wrap    = i_tick && (tick_cnt == osm - 5'd1);

  assign last_bit  = ({{(4-BW){1'b0}}, bit_cnt} == dlen - 4'd1);
  assign last_stop = stop2 ? stop_cnt : 1'b1;
  assign par_exp   = (^shreg) ^ ~par_even;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (fall) state_n = START;
      START: begin
        if (smp_hit && rx_s) state_n = IDLE;
        else if (wrap)       state_n = DATA;
      end
      DATA:   if (wrap && last_bit)
                state_n = par_en ? PARITY : STOP;
      PARITY: if (wrap) state_n = STOP;
      STOP:   if (smp_hit && last_stop) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sync_q   <= '1;
      rx_d     <= 1'b1;
      par_en   <= 1'b0;
      par_even <= 1'b0;
      stop2    <= 1'b0;
      dlen     <= 4'd8;
      osm      <= 5'd16;
      smp      <= 4'd0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], i_rx};
      rx_d    <= rx_s;
      state   <= state_n;
      valid_q <= 1'b0;

      if (i_tick && state != IDLE)
        tick_cnt <= wrap ? 5'd0 : tick_cnt + 5'd1;

      case (state)
        IDLE: if (fall) begin
          par_en   <= i_parity_en;
          par_even <= i_parity_even;
          stop2    <= (i_stop_len != 2'd0);
          dlen     <= dlen_c;
          osm      <= i_osm;
          smp      <= i_smp_nth;
          tick_cnt <= '0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          shreg    <= '0;
          par_err  <= 1'b0;
          frm_err  <= 1'b0;
        end
        DATA: begin
          if (smp_hit) shreg[bit_cnt] <= rx_s;
          if (wrap && !last_bit) bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY: begin
          if (smp_hit) par_err <= (rx_s != par_exp);
          if (wrap) stop_cnt <= 1'b0;
        end
        STOP: begin
          if (smp_hit) begin
            frm_err <= frm_err | ~rx_s;
            // Leave on the last stop sample to resync early.
            if (last_stop) begin
              valid_q <= 1'b1;
              data_q  <= shreg;
              pe_q    <= par_err;
              fe_q    <= frm_err | ~rx_s;
            end
          end
          if (wrap) stop_cnt <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rx_out.o_data       = data_q;
  assign rx_out.o_valid      = valid_q;
  assign rx_out.o_parity_err = pe_q;
  assign rx_out.o_frame_err  = fe_q;
  assign rx_out.o_busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: osm=16, smp_nth=7, tick every clk.
// Line bits driven 16 clks each; frames captured from o_valid pulses.
module tb_uart_rx_frame;
  logic       clk;
  logic       rst_n;
  logic       i_tick;
  logic       i_rx;
  logic       i_parity_en;
  logic       i_parity_even;
  logic [3:0] i_data_len;
  logic [1:0] i_stop_len;
  logic [4:0] i_osm;
  logic [3:0] i_smp_nth;

  uart_rx_frame_if #(.DATA_W(8)) bus ();

  uart_rx_frame #(
    .SYNC_STAGES(2),
    .DATA_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_tick(i_tick),
    .i_rx(i_rx),
    .i_parity_en(i_parity_en),
    .i_parity_even(i_parity_even),
    .i_data_len(i_data_len),
    .i_stop_len(i_stop_len),
    .i_osm(i_osm),
    .i_smp_nth(i_smp_nth),
    .rx_out(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int t0 = 0;

  int         vcnt = 0;
  int         v_cyc = 0;
  logic [7:0] cap_data = '0;
  logic       cap_pe = 1'b0;
  logic       cap_fe = 1'b0;

  always @(negedge clk) begin
    if (bus.o_valid === 1'b1) begin
      vcnt     = vcnt + 1;
      v_cyc    = cyc;
      cap_data = bus.o_data;
      cap_pe   = bus.o_parity_err;
      cap_fe   = bus.o_frame_err;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time();
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input int nb,
                            input bit has_par,
                            input bit par_v,
                            input int nstop,
                            input bit stop_v,
                            input bit chg_len);
    @(posedge clk);
    #1;
    t0 = cyc;
    i_rx = 1'b0;
    bit_time();
    if (chg_len) i_data_len = 4'd8;
    for (int i = 0; i < nb; i++) begin
      i_rx = d[i];
      bit_time();
    end
    if (has_par) begin
      i_rx = par_v;
      bit_time();
    end
    for (int i = 0; i < nstop; i++) begin
      i_rx = stop_v;
      bit_time();
    end
    i_rx = 1'b1;
    repeat (2) bit_time();
  endtask

  task automatic set_cfg(input bit pen, input bit pev,
                         input logic [3:0] len,
                         input logic [1:0] stp);
    i_parity_en   = pen;
    i_parity_even = pev;
    i_data_len    = len;
    i_stop_len    = stp;
  endtask

  initial begin
    int vc;
    rst_n  = 1'b0;
    i_tick = 1'b1;
    i_rx   = 1'b1;
    i_osm  = 5'd16;
    i_smp_nth = 4'd7;
    set_cfg(1'b0, 1'b0, 4'd8, 2'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_data", {24'd0, bus.o_data}, 32'd0);
    chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst_pe_fe", {30'd0, bus.o_parity_err, bus.o_frame_err}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // 8N1 0xA5, latency: 2 sync + 1 edge + 8 to sample + 9*16
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    chk("8n1_cnt", vcnt, 32'd1);
    chk("8n1_data", {24'd0, cap_data}, 32'hA5);
    chk("8n1_err", {30'd0, cap_pe, cap_fe}, 32'd0);
    chk("8n1_lat", v_cyc - t0, 32'd155);
    chk("8n1_hold", {24'd0, bus.o_data}, 32'hA5);

    // 7E2 0x5A: four ones -> even parity bit 0
    set_cfg(1'b1, 1'b1, 4'd7, 2'd1);
    send_frame(8'h5A, 7, 1'b1, 1'b0, 2, 1'b1, 1'b0);
    chk("7e2_cnt", vcnt, 32'd2);
    chk("7e2_data", {24'd0, cap_data}, 32'h5A);
    chk("7e2_err", {30'd0, cap_pe, cap_fe}, 32'd0);
    send_frame(8'h5A, 7, 1'b1, 1'b1, 2, 1'b1, 1'b0);
    chk("7e2_bad_cnt", vcnt, 32'd3);
    chk("7e2_bad_data", {24'd0, cap_data}, 32'h5A);
    chk("7e2_bad_err", {30'd0, cap_pe, cap_fe}, 32'b10);

    // 8O1 0x00 with odd parity bit 1, then stop forced low
    set_cfg(1'b1, 1'b0, 4'd8, 2'd0);
    send_frame(8'h00, 8, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    chk("8o1_cnt", vcnt, 32'd4);
    chk("8o1_data", {24'd0, cap_data}, 32'h00);
    chk("8o1_err", {30'd0, cap_pe, cap_fe}, 32'd0);
    send_frame(8'h00, 8, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    chk("8o1_fe_cnt", vcnt, 32'd5);
    chk("8o1_fe_data", {24'd0, cap_data}, 32'h00);
    chk("8o1_fe_err", {30'd0, cap_pe, cap_fe}, 32'b01);

    // Glitch: 3 clks low is a false start
    set_cfg(1'b0, 1'b0, 4'd8, 2'd0);
    vc = vcnt;
    @(posedge clk);
    #1;
    i_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_rx = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy", {31'd0, bus.o_busy}, 32'd1);
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("glitch_idle", {31'd0, bus.o_busy}, 32'd0);
    chk("glitch_nov", vcnt, vc);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    chk("post_gl_cnt", vcnt, vc + 1);
    chk("post_gl_data", {24'd0, cap_data}, 32'h3C);
    chk("post_gl_err", {30'd0, cap_pe, cap_fe}, 32'd0);

    // 5N1 0x1F, data_len changed to 8 after start bit
    set_cfg(1'b0, 1'b0, 4'd5, 2'd0);
    vc = vcnt;
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    chk("5n1_cnt", vcnt, vc + 1);
    chk("5n1_data", {24'd0, cap_data}, 32'h1F);
    chk("5n1_err", {30'd0, cap_pe, cap_fe}, 32'd0);

    // Reset in the middle of DATA, then frame 0x81
    set_cfg(1'b0, 1'b0, 4'd8, 2'd0);
    vc = vcnt;
    @(posedge clk);
    #1;
    i_rx = 1'b0;
    bit_time();
    i_rx = 1'b1;
    bit_time();
    i_rx = 1'b0;
    bit_time();
    bit_time();
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("mrst_data", {24'd0, bus.o_data}, 32'd0);
    chk("mrst_valid", {31'd0, bus.o_valid}, 32'd0);
    i_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    chk("mrst_nov", vcnt, vc);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    chk("post_rst_cnt", vcnt, vc + 1);
    chk("post_rst_data", {24'd0, cap_data}, 32'h81);
    chk("post_rst_err", {30'd0, cap_pe, cap_fe}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
